// File: rtl/rng_share_if.sv
// Requester-side bundle of the shared RNG arbiter: request levels in, grant/word back.
interface rng_share_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [31:0]        rnd_out;
  logic               rnd_valid;

  modport master (output req, input gnt, input rnd_out, input rnd_valid);
  modport slave  (input req, output gnt, output rnd_out, output rnd_valid);
endinterface

// File: rtl/rng_share_arbiter.sv
// One free-running xorshift32 generator shared round-robin among NUM_REQ requesters,
// with reseed, warm-up discard and a registered one-hot grant.
module xorshift32 #(
  parameter logic [31:0] RESET_VAL = 32'h2545F491
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        re_seed,
  output logic [31:0] state
);
  function automatic logic [31:0] step(input logic [31:0] s);
    logic [31:0] x;
    x = s ^ (s << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= RESET_VAL;
    else if (re_seed) state <= seed;
    else              state <= step(state);
  end
endmodule

module rng_share_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WARM_CYCLES  = 8,
  parameter logic [31:0] SEED_DEFAULT = 32'h2545F491
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  seed_in,
  input  logic         seed_wr,
  rng_share_if.slave   bus,
  output logic         busy,
  output logic         seed_zero_err,
  output logic [31:0]  grant_count
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {SEED, WARM, SERVE} state_t;

  state_t             state;
  logic [31:0]        pending_seed;
  logic [CNT_W-1:0]   warm_cnt;
  logic [IDX_W-1:0]   last_idx;
  logic [NUM_REQ-1:0] gnt_q;
  logic [31:0]        rnd_q;
  logic               valid_q;
  logic [31:0]        gen_state;
  logic               re_seed;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  int unsigned        cand;

  assign re_seed       = (state == SEED);
  assign bus.gnt       = gnt_q;
  assign bus.rnd_out   = rnd_q;
  assign bus.rnd_valid = valid_q;

  xorshift32 #(.RESET_VAL(SEED_DEFAULT)) u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .seed    (pending_seed),
    .re_seed (re_seed),
    .state   (gen_state)
  );

  // Round-robin search upward from the slot after the last grant.
  always_comb begin
    pick_idx   = last_idx;
    pick_found = 1'b0;
    cand       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_idx) + i) % NUM_REQ;
      if (!pick_found && bus.req[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SEED;
      pending_seed  <= SEED_DEFAULT;
      warm_cnt      <= '0;
      last_idx      <= IDX_W'(NUM_REQ - 1);
      gnt_q         <= '0;
      valid_q       <= 1'b0;
      rnd_q         <= '0;
      busy          <= 1'b1;
      seed_zero_err <= 1'b0;
      grant_count   <= '0;
    end else begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      // A reseed strobe overrides everything, including a same-cycle request.
      if (seed_wr) begin
        pending_seed <= (seed_in == 32'd0) ? SEED_DEFAULT : seed_in;
        if (seed_in == 32'd0) seed_zero_err <= 1'b1;
        state    <= SEED;
        busy     <= 1'b1;
        warm_cnt <= '0;
      end else begin
        case (state)
          SEED: begin
            state    <= WARM;
            warm_cnt <= '0;
            busy     <= 1'b1;
          end
          WARM: begin
            if (warm_cnt == CNT_W'(WARM_CYCLES - 1)) begin
              state <= SERVE;
              busy  <= 1'b0;
            end else begin
              warm_cnt <= warm_cnt + CNT_W'(1);
            end
          end
          SERVE: begin
            if (pick_found) begin
              gnt_q       <= NUM_REQ'(1) << pick_idx;
              valid_q     <= 1'b1;
              rnd_q       <= gen_state;
              last_idx    <= pick_idx;
              grant_count <= grant_count + 32'd1;
            end
          end
          default: begin
            state <= SEED;
            busy  <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rng_share_arbiter.sv
// Directed bench for rng_share_arbiter (NUM_REQ=4, WARM_CYCLES=1).
module tb_rng_share_arbiter;
  localparam logic [31:0] SEED_D = 32'h2545F491;

  logic        clk;
  logic        rst_n;
  logic [31:0] seed_in;
  logic        seed_wr;
  logic        busy;
  logic        seed_zero_err;
  logic [31:0] grant_count;

  rng_share_if #(.NUM_REQ(4)) bus ();

  rng_share_arbiter #(.NUM_REQ(4), .WARM_CYCLES(1), .SEED_DEFAULT(SEED_D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seed_in       (seed_in),
    .seed_wr       (seed_wr),
    .bus           (bus),
    .busy          (busy),
    .seed_zero_err (seed_zero_err),
    .grant_count   (grant_count)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  int          n_pass;
  int          n_total;
  vec_t        vecs [12];
  logic [31:0] g;
  logic [31:0] exp_rnd;
  logic [31:0] prev_rnd;
  logic [31:0] cnt;
  int          nb;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] x;
    x = s ^ (s << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; seed_in = '0; seed_wr = 1'b0; bus.req = '0;
    n_pass = 0; n_total = 0;
    // req pattern -> expected grant, starting with last granted index 3
    vecs[0]  = '{4'b1010, 4'b0010};
    vecs[1]  = '{4'b1010, 4'b1000};
    vecs[2]  = '{4'b0000, 4'b0000};
    vecs[3]  = '{4'b0100, 4'b0100};
    vecs[4]  = '{4'b0100, 4'b0100};
    vecs[5]  = '{4'b1001, 4'b1000};
    vecs[6]  = '{4'b1001, 4'b0001};
    vecs[7]  = '{4'b0110, 4'b0010};
    vecs[8]  = '{4'b0001, 4'b0001};
    vecs[9]  = '{4'b1110, 4'b0010};
    vecs[10] = '{4'b1100, 4'b0100};
    vecs[11] = '{4'b0000, 4'b0000};

    tick(); tick();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_valid", 32'(bus.rnd_valid), 32'h0);
    chk("rst_rnd", bus.rnd_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_err", 32'(seed_zero_err), 32'h0);
    chk("rst_count", grant_count, 32'h0);

    // seed 1, one warm cycle, first request
    rst_n = 1'b1; seed_wr = 1'b1; seed_in = 32'd1;
    tick(); seed_wr = 1'b0;
    chk("s1_busy_a", 32'(busy), 32'h1);
    tick();
    chk("s1_busy_b", 32'(busy), 32'h1);
    tick();
    chk("s1_busy_c", 32'(busy), 32'h0);
    chk("s1_gnt_idle", 32'(bus.gnt), 32'h0);
    bus.req = 4'b0001;
    tick();
    chk("s1_gnt", 32'(bus.gnt), 32'h1);
    chk("s1_valid", 32'(bus.rnd_valid), 32'h1);
    chk("s1_rnd", bus.rnd_out, 32'h00042021);
    chk("s1_count", grant_count, 32'd1);
    bus.req = 4'b0000;
    tick();
    chk("s1_gnt_off", 32'(bus.gnt), 32'h0);
    chk("s1_valid_off", 32'(bus.rnd_valid), 32'h0);
    chk("s1_rnd_hold", bus.rnd_out, 32'h00042021);

    // fresh reset, all requesting
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tick(); tick();
    chk("rr_ready", 32'(busy), 32'h0);
    g = xs(SEED_D); cnt = 0; prev_rnd = '0; exp_rnd = '0;
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << (k % 4)));
      chk("rr_valid", 32'(bus.rnd_valid), 32'h1);
      chk("rr_rnd", bus.rnd_out, g);
      if (k > 0) chk("rr_distinct", 32'(bus.rnd_out != prev_rnd), 32'h1);
      prev_rnd = bus.rnd_out; exp_rnd = g; g = xs(g); cnt++;
    end
    chk("rr_count", grant_count, cnt);

    for (int v = 0; v < 12; v++) begin
      bus.req = vecs[v].req;
      tick();
      chk($sformatf("vec%0d_gnt", v), 32'(bus.gnt), 32'(vecs[v].gnt));
      chk($sformatf("vec%0d_valid", v), 32'(bus.rnd_valid), 32'(vecs[v].gnt != 4'b0));
      if (vecs[v].gnt != 4'b0) begin exp_rnd = g; cnt++; end
      chk($sformatf("vec%0d_rnd", v), bus.rnd_out, exp_rnd);
      g = xs(g);
    end
    chk("vec_count", grant_count, cnt);

    // zero seed: substitution, sticky error, busy length, seed_wr beats req
    chk("zero_err_pre", 32'(seed_zero_err), 32'h0);
    bus.req = 4'b1111; seed_in = 32'd0; seed_wr = 1'b1;
    tick(); seed_wr = 1'b0;
    chk("zero_err", 32'(seed_zero_err), 32'h1);
    nb = 0;
    for (int i = 0; i < 10 && busy; i++) begin
      nb++;
      chk("zero_gnt_busy", 32'(bus.gnt), 32'h0);
      tick();
    end
    chk("zero_busy_len", 32'(nb), 32'd2);
    tick();
    chk("zero_gnt", 32'(bus.gnt), 32'b1000);
    chk("zero_rnd", bus.rnd_out, xs(SEED_D));
    cnt++;

    // reseed during warm-up restarts the sequence
    seed_in = 32'h0000_1234; seed_wr = 1'b1;
    tick(); seed_wr = 1'b0;
    chk("rw_busy_a", 32'(busy), 32'h1);
    chk("rw_gnt_a", 32'(bus.gnt), 32'h0);
    tick();
    chk("rw_busy_b", 32'(busy), 32'h1);
    seed_in = 32'hCAFE_0001; seed_wr = 1'b1;
    tick(); seed_wr = 1'b0;
    chk("rw_busy_c", 32'(busy), 32'h1);
    chk("rw_gnt_c", 32'(bus.gnt), 32'h0);
    tick();
    chk("rw_busy_d", 32'(busy), 32'h1);
    chk("rw_gnt_d", 32'(bus.gnt), 32'h0);
    tick();
    chk("rw_busy_e", 32'(busy), 32'h0);
    chk("rw_gnt_e", 32'(bus.gnt), 32'h0);
    tick();
    chk("rw_gnt", 32'(bus.gnt), 32'b0001);
    chk("rw_rnd", bus.rnd_out, xs(32'hCAFE_0001));
    chk("rw_err_sticky", 32'(seed_zero_err), 32'h1);
    cnt++;
    chk("rw_count", grant_count, cnt);

    // grant counter wrap
    force dut.grant_count = 32'hFFFF_FFFF;
    #1;
    release dut.grant_count;
    tick();
    chk("wrap_gnt", 32'(bus.gnt), 32'b0010);
    chk("wrap_count", grant_count, 32'h0);
    tick();
    chk("wrap_count_next", grant_count, 32'h1);

    // reset pulse during an active grant
    rst_n = 1'b0;
    #1;
    chk("pulse_gnt", 32'(bus.gnt), 32'h0);
    chk("pulse_valid", 32'(bus.rnd_valid), 32'h0);
    chk("pulse_rnd", bus.rnd_out, 32'h0);
    chk("pulse_busy", 32'(busy), 32'h1);
    chk("pulse_count", grant_count, 32'h0);
    chk("pulse_err", 32'(seed_zero_err), 32'h0);
    tick(); rst_n = 1'b1;
    tick();
    chk("pulse_gnt_seed", 32'(bus.gnt), 32'h0);
    chk("pulse_busy_seed", 32'(busy), 32'h1);
    tick();
    chk("pulse_gnt_warm", 32'(bus.gnt), 32'h0);
    chk("pulse_busy_serve", 32'(busy), 32'h0);
    tick();
    chk("pulse_resume_gnt", 32'(bus.gnt), 32'b0001);
    chk("pulse_resume_rnd", bus.rnd_out, xs(SEED_D));
    chk("pulse_resume_count", grant_count, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rng_share_arbiter.md
RNG_SHARE_ARBITER -- requirements
Module: rng_share_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter WARM_CYCLES, default 8, giving the number of generator outputs discarded after every seed load (range 1..255).
REQ-003 The block SHALL have parameter SEED_DEFAULT, default 32'h2545F491, giving the seed used at reset and in place of any zero seed.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port seed_in, input, 32 bits: new seed value, sampled when seed_wr=1.
REQ-007 The block SHALL have port seed_wr, input, 1 bit: single-cycle reseed strobe.
REQ-008 The block SHALL have port req, input, NUM_REQ bits: level request per requester.
REQ-009 The block SHALL have port gnt, output, NUM_REQ bits: registered one-hot grant pulse.
REQ-010 The block SHALL have port rnd_out, output, 32 bits: random word delivered to the granted requester.
REQ-011 The block SHALL have port rnd_valid, output, 1 bit: high exactly when gnt is non-zero.
REQ-012 The block SHALL have port busy, output, 1 bit: high while seeding or warming up.
REQ-013 The block SHALL have port seed_zero_err, output, 1 bit: sticky flag set when a zero seed was written.
REQ-014 The block SHALL have port grant_count, output, 32 bits: total grants issued, wrapping modulo 2^32.

Function
REQ-015 The block SHALL instantiate exactly one xorshift32 generator, shared by all requesters, driving its clk/rst_n from the block ports and its seed/re_seed from the FSM.
REQ-016 The FSM SHALL have states SEED, WARM and SERVE; reset enters SEED.
REQ-017 In SEED the block SHALL assert re_seed to the generator for exactly one cycle with the pending seed, then go to WARM.
REQ-018 In WARM the block SHALL count WARM_CYCLES cycles, ignoring req, then go to SERVE.
REQ-019 busy SHALL be 1 in SEED and WARM and 0 in SERVE.
REQ-020 The pending seed SHALL be SEED_DEFAULT after reset, otherwise the last seed_in written; a written seed_in of 0 SHALL be replaced by SEED_DEFAULT and SHALL set seed_zero_err.
REQ-021 seed_wr=1 in any state SHALL latch seed_in and enter SEED on the next cycle, aborting any warm-up in progress; a seed_wr in the same cycle as req SHALL win, and no grant is issued.
REQ-022 In SERVE, when req is non-zero, the block SHALL choose one requester round-robin, searching upward from (last granted index + 1) modulo NUM_REQ.
REQ-023 The grant SHALL be registered: one cycle after the req sample, gnt is one-hot for the chosen index, rnd_valid=1, and rnd_out equals the generator state during the sampling cycle.
REQ-024 When no grant is issued, gnt SHALL be 0 and rnd_valid SHALL be 0; rnd_out SHALL hold its last value.
REQ-025 The generator SHALL free-run every cycle, so no generator word is delivered twice and at most one grant is issued per cycle.
REQ-026 grant_count SHALL increment by 1 in the cycle gnt becomes non-zero, wrapping 32'hFFFFFFFF to 0.
REQ-027 A requester holding req continuously SHALL be granted at least once every NUM_REQ SERVE cycles.

Reset
REQ-028 While rst_n=0, the outputs SHALL be: gnt=0, rnd_valid=0, rnd_out=0, busy=1, seed_zero_err=0, grant_count=0; the last-grant pointer SHALL be NUM_REQ-1 so requester 0 wins first; FSM=SEED.
REQ-029 Asserting rst_n=0 mid-warm-up or mid-service SHALL abandon all state immediately, with no grant pulse after deassertion until SERVE is re-entered.

Verification
REQ-030 Reset release, WARM_CYCLES=1, seed_wr with seed_in=1 (SEED then 1 WARM), then req=4'b0001 in the first SERVE cycle -> next cycle gnt=4'b0001, rnd_out=32'h00042021, grant_count=1.
REQ-031 req=4'b1111 held for 8 SERVE cycles after reset -> grants 0,1,2,3,0,1,2,3 in order, rnd_valid=1 each cycle, and 8 distinct consecutive generator words.
REQ-032 seed_wr with seed_in=0 -> seed_zero_err=1 (sticky); generator loaded with 32'h2545F491; busy=1 for 1+WARM_CYCLES cycles.
REQ-033 seed_wr during WARM with req=4'b1111 -> busy stays 1, warm-up restarts from SEED, and no gnt until the full WARM_CYCLES elapse.
REQ-034 grant_count forced near wrap (32'hFFFFFFFF) via continuous req -> next grant gives grant_count=0.
REQ-035 rst_n pulsed low for one cycle while gnt is active -> gnt=0, rnd_out=0, busy=1 immediately, and service resumes only after SEED+WARM.
